correlator_bank: RTL and testbench

- Parametrised successor to the single fixed-code correlator pair.
- Correlates one digitised 1-bit stream against CHANNELS runtime-loadable CODE_LEN-bit codes over a fixed window of 2^WIN_LOG2 samples.
- Latches per-channel match counts and sequentially scans them for the best channel.
- Tracks a lock condition across consecutive windows; sits between the digitizer and the LED/tx reporting logic.

---
 rtl/corr_pkg.sv | 27 ++
 rtl/correlator_lane.sv | 50 +++++
 rtl/correlator_bank.sv | 168 ++++++++++++++++
 tb/tb_correlator_bank.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared definitions for the correlator bank: width helpers and the
// scan FSM encoding.
package corr_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // A full window of matches is 2^WIN_LOG2, which needs one extra bit.
    function automatic int acc_w(input int win_log2);
        return win_log2 + 1;
    endfunction

endpackage

// File: rtl/correlator_lane.sv
// One correlator lane: loadable code, per-sample chip compare and a
// window accumulator whose final sum is latched at window end.
module correlator_lane
    import corr_pkg::*;
#(
    parameter int CODE_LEN = 8,
    parameter int ACC_W    = acc_w(8),
    parameter int PH_W     = idx_w(CODE_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                code_load,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                sample_en,
    input  logic                sig,
    input  logic [PH_W-1:0]     phase,
    input  logic                win_end,
    output logic [ACC_W-1:0]    value
);

    logic [CODE_LEN-1:0] r_code;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_value;
    logic                w_match;
    logic [ACC_W-1:0]    w_sum;

    assign w_match = (sig == r_code[phase]);
    assign w_sum   = r_acc + ACC_W'(w_match);
    assign value   = r_value;

    // win_end arrives already qualified by sample_en and by the absence of code_load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code  <= '0;
            r_acc   <= '0;
            r_value <= '0;
        end else if (code_load) begin
            r_code <= code_in;
            r_acc  <= '0;
        end else if (sample_en) begin
            if (win_end) begin
                r_value <= w_sum;
                r_acc   <= '0;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

endmodule

// File: rtl/correlator_bank.sv
// Bank of CHANNELS correlator lanes sharing one phase/window counter,
// with a sequential best-lane scan and a consecutive-window lock tracker.
module correlator_bank
    import corr_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CODE_LEN = 8,
    parameter int WIN_LOG2 = 8,
    parameter int THRESH   = 192,
    parameter int LOCK_CNT = 3,
    localparam int ACC_W   = acc_w(WIN_LOG2),
    localparam int IDX_W   = idx_w(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_en,
    input  logic                         sig,
    input  logic                         code_load,
    input  logic [CHANNELS*CODE_LEN-1:0] codes_in,
    output logic [CHANNELS*ACC_W-1:0]    value,
    output logic                         value_valid,
    output logic [IDX_W-1:0]             best_idx,
    output logic [ACC_W-1:0]             best_value,
    output logic                         best_valid,
    output logic                         locked
);

    localparam int PH_W = idx_w(CODE_LEN);
    localparam int LC_W = idx_w(LOCK_CNT + 1);

    // The scan must finish before the next window can possibly end.
    generate
        if (CHANNELS < 1 || CODE_LEN < 2 || LOCK_CNT < 1 || (2 ** WIN_LOG2) < CHANNELS + 1) begin : g_bad_params
            $error("correlator_bank: invalid parameter combination");
        end
    endgenerate

    logic [PH_W-1:0]           r_phase;
    logic [WIN_LOG2-1:0]       r_win_cnt;
    scan_state_t               r_state;
    scan_state_t               w_state_nxt;
    logic [IDX_W-1:0]          r_scan_idx;
    logic [ACC_W-1:0]          r_run_max;
    logic [IDX_W-1:0]          r_run_idx;
    logic                      r_value_valid;
    logic [IDX_W-1:0]          r_best_idx;
    logic [ACC_W-1:0]          r_best_value;
    logic                      r_best_valid;
    logic [LC_W-1:0]           r_lock_cnt;
    logic                      r_locked;
    logic [CHANNELS*ACC_W-1:0] w_value;
    logic                      w_win_end;
    logic [ACC_W-1:0]          w_lane_val;
    logic                      w_scan_last;
    logic                      w_take;
    logic [ACC_W-1:0]          w_cand_val;
    logic [IDX_W-1:0]          w_cand_idx;
    logic                      w_good;
    logic [LC_W-1:0]           w_lock_nxt;

    assign w_win_end = sample_en && !code_load && (r_win_cnt == '1);

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
            correlator_lane #(
                .CODE_LEN (CODE_LEN),
                .ACC_W    (ACC_W),
                .PH_W     (PH_W)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .code_load (code_load),
                .code_in   (codes_in[k*CODE_LEN +: CODE_LEN]),
                .sample_en (sample_en),
                .sig       (sig),
                .phase     (r_phase),
                .win_end   (w_win_end),
                .value     (w_value[k*ACC_W +: ACC_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase   <= '0;
            r_win_cnt <= '0;
        end else if (code_load) begin
            r_phase   <= '0;
            r_win_cnt <= '0;
        end else if (sample_en) begin
            r_phase   <= (r_phase == PH_W'(CODE_LEN - 1)) ? '0 : r_phase + PH_W'(1);
            r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
        end
    end

    // Lowest index wins ties: index 0 seeds the running max, later lanes need strictly more.
    assign w_lane_val  = w_value[int'(r_scan_idx)*ACC_W +: ACC_W];
    assign w_scan_last = (r_scan_idx == IDX_W'(CHANNELS - 1));
    assign w_take      = (r_scan_idx == '0) || (w_lane_val > r_run_max);
    assign w_cand_val  = w_take ? w_lane_val : r_run_max;
    assign w_cand_idx  = w_take ? r_scan_idx : r_run_idx;
    assign w_good      = (w_cand_val >= ACC_W'(THRESH));
    assign w_lock_nxt  = !w_good ? '0 :
                         (r_lock_cnt == LC_W'(LOCK_CNT)) ? r_lock_cnt : r_lock_cnt + LC_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ACCUM;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_win_end) w_state_nxt = SCAN;
            SCAN:    if (w_scan_last) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value_valid <= 1'b0;
            r_scan_idx    <= '0;
            r_run_max     <= '0;
            r_run_idx     <= '0;
            r_best_idx    <= '0;
            r_best_value  <= '0;
            r_best_valid  <= 1'b0;
        end else begin
            r_value_valid <= w_win_end;
            r_best_valid  <= 1'b0;
            if (r_state == ACCUM) begin
                r_scan_idx <= '0;
            end else if (w_scan_last) begin
                r_best_idx   <= w_cand_idx;
                r_best_value <= w_cand_val;
                r_best_valid <= 1'b1;
                r_scan_idx   <= '0;
            end else begin
                r_run_max  <= w_cand_val;
                r_run_idx  <= w_cand_idx;
                r_scan_idx <= r_scan_idx + IDX_W'(1);
            end
        end
    end

    // A code change invalidates any lock history, even when a scan commits on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (code_load) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (r_state == SCAN && w_scan_last) begin
            r_lock_cnt <= w_lock_nxt;
            r_locked   <= (w_lock_nxt == LC_W'(LOCK_CNT));
        end
    end

    assign value       = w_value;
    assign value_valid = r_value_valid;
    assign best_idx    = r_best_idx;
    assign best_value  = r_best_value;
    assign best_valid  = r_best_valid;
    assign locked      = r_locked;

endmodule

// File: tb/tb_correlator_bank.sv
// Directed bench for correlator_bank: 2 lanes, 4-chip codes, 16-sample windows,
// threshold 12, lock after 2 good windows.
module tb_correlator_bank;

    localparam int CH = 2;
    localparam int CL = 4;
    localparam int WL = 4;
    localparam int AW = WL + 1;

    logic            clk;
    logic            rst;
    logic            sample_en;
    logic            sig;
    logic            code_load;
    logic [CH*CL-1:0] codes_in;
    logic [CH*AW-1:0] value;
    logic            value_valid;
    logic [0:0]      best_idx;
    logic [AW-1:0]   best_value;
    logic            best_valid;
    logic            locked;

    int n_tests;
    int n_fail;

    correlator_bank #(
        .CHANNELS (CH),
        .CODE_LEN (CL),
        .WIN_LOG2 (WL),
        .THRESH   (12),
        .LOCK_CNT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .sig         (sig),
        .code_load   (code_load),
        .codes_in    (codes_in),
        .value       (value),
        .value_valid (value_valid),
        .best_idx    (best_idx),
        .best_value  (best_value),
        .best_valid  (best_valid),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: sig 1,0,1,0...  mode 1: constant 1  mode 2: constant 0
    task automatic feed(input int mode, input bit every_other, output int vv_cnt, output int vv_at);
        int n_clk;
        int idx;
        n_clk  = every_other ? 31 : 16;
        vv_cnt = 0;
        vv_at  = -1;
        for (int c = 0; c < n_clk; c++) begin
            sample_en = every_other ? (c % 2 == 0) : 1'b1;
            idx       = every_other ? c / 2 : c;
            case (mode)
                0:       sig = (idx % 2 == 0);
                1:       sig = 1'b1;
                default: sig = 1'b0;
            endcase
            tick;
            if (value_valid) begin
                vv_cnt++;
                vv_at = c;
            end
        end
        sample_en = 1'b0;
        sig       = 1'b0;
    endtask

    task automatic window(input string tag, input int mode, input bit eo,
                          input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                          input logic e_idx, input logic [AW-1:0] e_bv,
                          input logic e_lock_before, input logic e_lock);
        int cnt;
        int at;
        feed(mode, eo, cnt, at);
        check({tag, ".vv_count"}, cnt, 1);
        check({tag, ".vv_clock"}, at, eo ? 30 : 15);
        check({tag, ".value"}, 32'(value), 32'({e1, e0}));
        tick;
        check({tag, ".vv_drop"}, 32'(value_valid), 32'd0);
        check({tag, ".bv_early"}, 32'(best_valid), 32'd0);
        check({tag, ".lock_hold"}, 32'(locked), 32'(e_lock_before));
        tick;
        check({tag, ".best_valid"}, 32'(best_valid), 32'd1);
        check({tag, ".best_idx"}, 32'(best_idx), 32'(e_idx));
        check({tag, ".best_value"}, 32'(best_value), 32'(e_bv));
        check({tag, ".locked"}, 32'(locked), 32'(e_lock));
        tick;
        check({tag, ".bv_drop"}, 32'(best_valid), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".value"}, 32'(value), 32'd0);
        check({tag, ".value_valid"}, 32'(value_valid), 32'd0);
        check({tag, ".best_idx"}, 32'(best_idx), 32'd0);
        check({tag, ".best_value"}, 32'(best_value), 32'd0);
        check({tag, ".best_valid"}, 32'(best_valid), 32'd0);
        check({tag, ".locked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        int cnt;
        int at;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        sample_en = 1'b0;
        sig       = 1'b0;
        code_load = 1'b0;
        codes_in  = '0;
        #3;
        check_zero("reset0");
        tick;
        tick;
        rst = 1'b1;

        // ch1 = 1010, ch0 = 0101
        codes_in  = {4'b1010, 4'b0101};
        code_load = 1'b1;
        tick;
        code_load = 1'b0;
        check("load.vv", 32'(value_valid), 32'd0);

        window("alt1",   0, 1'b0, 5'd16, 5'd0, 1'b0, 5'd16, 1'b0, 1'b0);
        window("const1", 1, 1'b0, 5'd8,  5'd8, 1'b0, 5'd8,  1'b0, 1'b0);
        window("alt2",   0, 1'b0, 5'd16, 5'd0, 1'b0, 5'd16, 1'b0, 1'b0);
        window("alt3",   0, 1'b0, 5'd16, 5'd0, 1'b0, 5'd16, 1'b0, 1'b1);
        window("const2", 1, 1'b0, 5'd8,  5'd8, 1'b0, 5'd8,  1'b1, 1'b0);
        window("half",   0, 1'b1, 5'd16, 5'd0, 1'b0, 5'd16, 1'b0, 1'b0);
        window("alt4",   0, 1'b0, 5'd16, 5'd0, 1'b0, 5'd16, 1'b0, 1'b1);

        // Eight samples, then reload on the ninth with swapped codes.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            sample_en = 1'b1;
            sig       = (i % 2 == 0);
            tick;
            if (value_valid) cnt++;
        end
        check("partial.vv", cnt, 0);
        sample_en = 1'b1;
        sig       = 1'b1;
        codes_in  = {4'b0101, 4'b1010};
        code_load = 1'b1;
        tick;
        code_load = 1'b0;
        sample_en = 1'b0;
        check("reload.locked", 32'(locked), 32'd0);
        check("reload.vv", 32'(value_valid), 32'd0);
        window("newcode", 0, 1'b0, 5'd0, 5'd16, 1'b1, 5'd16, 1'b0, 1'b0);
        window("newcode2", 0, 1'b0, 5'd0, 5'd16, 1'b1, 5'd16, 1'b0, 1'b1);

        // Reset asserted between edges while the scan is in progress.
        feed(0, 1'b0, cnt, at);
        check("prerst.vv_clock", at, 15);
        check("prerst.value", 32'(value), 32'({5'd16, 5'd0}));
        tick;
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        tick;
        tick;
        #2;
        rst = 1'b1;
        // Codes were cleared, so all-zero codes match a constant-0 stream.
        window("postrst", 2, 1'b0, 5'd16, 5'd16, 1'b0, 5'd16, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
